// File: rtl/si_stats_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// si_stats_pkg : shared types and constants for the statistics poller
// Rev 1.0
// ---------------------------------------------------------------------------
package si_stats_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    REQ  = 2'd2,
    PUSH = 2'd3
  } state_e;

  localparam logic [15:0] STATS_HDR_MAGIC    = 16'h5354;
  localparam logic [31:0] STATS_TIMEOUT_FILL = 32'hDEAD_BEEF;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/si_stats_poll_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// si_stats_poll_timer : period timer, pending request flag, missed-request count
// Rev 1.0
// ---------------------------------------------------------------------------
module si_stats_poll_timer
  import si_stats_pkg::*;
#(
  parameter int POLL_PERIOD = 100000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        trigger_i,
  input  logic        idle_i,
  input  logic        clear_i,
  output logic        pending_o,
  output logic [15:0] missed_o
);

  localparam logic [31:0] RELOAD = (POLL_PERIOD == 0) ? 32'd0 : 32'(POLL_PERIOD - 1);

  logic [31:0] timer_q, timer_d;
  logic        pending_q, pending_d;
  logic [15:0] missed_q, missed_d;
  logic        w_tfire, w_trig;
  logic [1:0]  w_n, w_miss;

  assign w_tfire = enable_i && (POLL_PERIOD != 0) && (timer_q == 32'd0);
  assign w_trig  = enable_i && trigger_i;
  assign w_n     = {1'b0, w_tfire} + {1'b0, w_trig};

  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    w_miss    = 2'd0;
    if (enable_i && (POLL_PERIOD != 0)) begin
      timer_d = (timer_q == 32'd0) ? RELOAD : timer_q - 32'd1;
    end
    // Every firing source is a miss when a request is already queued or running;
    // otherwise one of them becomes the request and the rest are misses.
    if (pending_q || !idle_i) begin
      w_miss = w_n;
    end else if (w_n != 2'd0) begin
      w_miss = w_n - 2'd1;
    end
    if (w_n != 2'd0) begin
      pending_d = 1'b1;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
    missed_d = sat_add16(missed_q, w_miss);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q   <= RELOAD;
      pending_q <= 1'b0;
      missed_q  <= 16'd0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  assign pending_o = pending_q;
  assign missed_o  = missed_q;

endmodule
`default_nettype wire

// File: rtl/si_stats_poller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// si_stats_poller : Wishbone readout of the stats block streamed as AXIS records
// Rev 1.0
// ---------------------------------------------------------------------------
module si_stats_poller
  import si_stats_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int N_REGS      = 13,
  parameter int POLL_PERIOD = 100000000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic                  enable,
  input  logic                  trigger,
  output logic [ADDR_WIDTH-1:0] m_wb_adr_o,
  input  logic [31:0]           m_wb_dat_i,
  output logic                  m_wb_we_o,
  output logic                  m_wb_stb_o,
  output logic                  m_wb_cyc_o,
  input  logic                  m_wb_ack_i,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [15:0]           missed_triggers
);

  localparam logic [5:0]  LAST_IDX = 6'(N_REGS - 1);
  localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] data_q, data_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
  logic        w_pending, w_clear;

  si_stats_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_timer (
    .clk_i    (wb_clk),
    .rst_ni   (wb_rst_n),
    .enable_i (enable),
    .trigger_i(trigger),
    .idle_i   (state_q == IDLE),
    .clear_i  (w_clear),
    .pending_o(w_pending),
    .missed_o (missed_triggers)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    data_d    = data_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    w_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_pending) begin
          w_clear = 1'b1;
          idx_d   = 6'd0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (m_axis_tready) begin
          seq_d    = seq_q + 16'd1;
          to_cnt_d = 16'd0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (m_wb_ack_i) begin
          data_d  = m_wb_dat_i;
          state_d = PUSH;
        end else if (to_cnt_q == TO_LAST) begin
          data_d    = STATS_TIMEOUT_FILL;
          timeout_d = 1'b1;
          state_d   = PUSH;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      PUSH: begin
        if (m_axis_tready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d    = idx_q + 6'd1;
            to_cnt_d = 16'd0;
            state_d  = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 6'd0;
      seq_q     <= 16'd0;
      data_q    <= 32'd0;
      to_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      data_q    <= data_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // All outputs decode registered state only; no input reaches an output combinationally.
  assign m_wb_we_o     = 1'b0;
  assign m_wb_cyc_o    = (state_q == REQ);
  assign m_wb_stb_o    = (state_q == REQ);
  assign m_wb_adr_o    = (state_q == REQ) ? ADDR_WIDTH'({idx_q, 2'b00}) : '0;
  assign m_axis_tvalid = (state_q == HDR) || (state_q == PUSH);
  assign m_axis_tdata  = (state_q == HDR)  ? {STATS_HDR_MAGIC, seq_q} :
                         (state_q == PUSH) ? data_q : 32'd0;
  assign m_axis_tlast  = (state_q == PUSH) && (idx_q == LAST_IDX);
  assign busy          = (state_q != IDLE);
  assign timeout_err   = timeout_q;

endmodule
`default_nettype wire
